apex_watch_ctrl: RTL and testbench

Parametrised watch/sequence controller that supersedes the fixed six-channel, seven-bit watch logic. One of N_CH active-low status lines is selected by an index and monitored. A watch counter runs toward a programmable terminal count. On a fault it captures a one-hot channel record, then runs an N_STEP post-fault sequence. It sits between the channel status fabric and the supervisory sequencer and exposes sticky error flags for the status register bank.

---
 rtl/apex_watch_pkg.sv | 18 +
 rtl/apex_watch_sel.sv | 19 +
 rtl/apex_watch_ctrl.sv | 115 +++++++++++
 tb/tb_apex_watch_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/apex_watch_pkg.sv
// apex_watch_pkg: shared state encoding, legality check and default sizing for the watch controller
package apex_watch_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_SEQ     = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4,
    S_KILL    = 3'd5
  } state_e;
  localparam int DEF_N_CH     = 6;
  localparam int DEF_CNT_W    = 7;
  localparam int DEF_TERMINAL = 82;
  localparam int DEF_N_STEP   = 4;
  function automatic logic legal_state(logic [2:0] s);
    return s <= 3'd5;
  endfunction
endpackage

// File: rtl/apex_watch_sel.sv
// apex_watch_sel: range-checked channel mux and one-hot decode of the selected channel
module apex_watch_sel #(
  parameter int N_CH  = 6,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [N_CH-1:0]  cat_n,
  output logic             sel_fault,
  output logic [N_CH-1:0]  onehot
);
  logic in_range;
  // extra bit keeps the compare correct when N_CH is a power of two
  assign in_range  = {1'b0, sel} < (SEL_W+1)'(N_CH);
  assign sel_fault = |(onehot & ~cat_n);
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_CH; i++) onehot[i] = in_range && (sel == SEL_W'(i));
  end
endmodule

// File: rtl/apex_watch_ctrl.sv
// apex_watch_ctrl: channel watch FSM with timeout counter, post-fault sequence and sticky error flags
module apex_watch_ctrl
  import apex_watch_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int SEL_W    = $clog2(N_CH),
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TERMINAL = DEF_TERMINAL,
  parameter int N_STEP   = DEF_N_STEP,
  parameter int STEP_W   = $clog2(N_STEP) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              start,
  input  logic              watch_en,
  input  logic              kbg_n,
  input  logic [SEL_W-1:0]  sel,
  input  logic [N_CH-1:0]   cat_n,
  output logic [2:0]        state,
  output logic              active,
  output logic [CNT_W-1:0]  watch_cnt,
  output logic [STEP_W-1:0] step,
  output logic [N_CH-1:0]   pluto,
  output logic              sdo,
  output logic              done,
  output logic              err_timeout,
  output logic              err_kill
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [N_CH-1:0] pluto_q, pluto_d, onehot;
  logic sdo_q, sdo_d, et_q, et_d, ek_q, ek_d, active_q, active_d, done_q, done_d, sel_fault;
  apex_watch_sel #(.N_CH(N_CH), .SEL_W(SEL_W)) u_sel (
    .sel(sel), .cat_n(cat_n), .sel_fault(sel_fault), .onehot(onehot)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    pluto_d = pluto_q;
    et_d    = et_q;
    ek_d    = ek_q;
    sdo_d   = sel_fault;
    if (clr) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      step_d  = '0;
      sdo_d   = 1'b0;
    end else if (!legal_state(state_q)) begin
      state_d = S_IDLE;
    end else if (!kbg_n && (state_q == S_ARM || state_q == S_SEQ)) begin
      state_d = S_KILL;
      ek_d    = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) begin
          state_d = S_ARM;
          cnt_d   = '0;
          step_d  = '0;
        end
        S_ARM: if (watch_en) begin
          if (cnt_q == CNT_W'(TERMINAL)) begin
            state_d = S_TIMEOUT;
            et_d    = 1'b1;
          end else if (sel_fault) begin
            state_d = S_SEQ;
            pluto_d = pluto_q | onehot;
            step_d  = '0;
          end else cnt_d = cnt_q + CNT_W'(1);
        end
        S_SEQ: begin
          state_d = (step_q == STEP_W'(N_STEP-1)) ? S_DONE : S_SEQ;
          step_d  = (step_q == STEP_W'(N_STEP-1)) ? step_q : step_q + STEP_W'(1);
        end
        default: ;
      endcase
    end
    active_d = (state_d == S_ARM) || (state_d == S_SEQ);
    done_d   = state_d == S_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      step_q   <= '0;
      pluto_q  <= '0;
      sdo_q    <= 1'b0;
      et_q     <= 1'b0;
      ek_q     <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      pluto_q  <= pluto_d;
      sdo_q    <= sdo_d;
      et_q     <= et_d;
      ek_q     <= ek_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end
  assign state       = state_q;
  assign active      = active_q;
  assign watch_cnt   = cnt_q;
  assign step        = step_q;
  assign pluto       = pluto_q;
  assign sdo         = sdo_q;
  assign done        = done_q;
  assign err_timeout = et_q;
  assign err_kill    = ek_q;
endmodule

// File: tb/tb_apex_watch_ctrl.sv
// tb_apex_watch_ctrl: directed vectors against the default and a wide-channel configuration
module tb_apex_watch_ctrl;
  logic clk = 1'b0, rst, clr, start, watch_en, kbg_n;
  logic [2:0] sel;
  logic [5:0] cat_n;
  logic [3:0] sel2;
  logic [11:0] cat2;
  logic [2:0] state, state2, step, step2;
  logic active, active2, sdo, sdo2, done, done2, et, et2, ek, ek2;
  logic [6:0] cnt;
  logic [9:0] cnt2;
  logic [5:0] pluto;
  logic [11:0] pluto2;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  apex_watch_ctrl dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .watch_en(watch_en), .kbg_n(kbg_n),
    .sel(sel), .cat_n(cat_n), .state(state), .active(active), .watch_cnt(cnt), .step(step),
    .pluto(pluto), .sdo(sdo), .done(done), .err_timeout(et), .err_kill(ek)
  );
  apex_watch_ctrl #(.N_CH(12), .CNT_W(10), .TERMINAL(600), .N_STEP(4)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .watch_en(watch_en), .kbg_n(kbg_n),
    .sel(sel2), .cat_n(cat2), .state(state2), .active(active2), .watch_cnt(cnt2), .step(step2),
    .pluto(pluto2), .sdo(sdo2), .done(done2), .err_timeout(et2), .err_kill(ek2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask
  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask
  initial begin
    rst = 1'b1; clr = 1'b0; start = 1'b0; watch_en = 1'b0; kbg_n = 1'b1;
    sel = 3'd0; cat_n = 6'h3F; sel2 = 4'd0; cat2 = 12'hFFF;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rst_state", state, 0); chk("rst_active", active, 0); chk("rst_cnt", cnt, 0);
    chk("rst_step", step, 0); chk("rst_pluto", pluto, 0); chk("rst_sdo", sdo, 0);
    chk("rst_done", done, 0); chk("rst_et", et, 0); chk("rst_ek", ek, 0);
    // fault on channel 3 after ten watched cycles
    watch_en = 1'b1;
    pulse_start();
    chk("arm_state", state, 1); chk("arm_active", active, 1); chk("arm_cnt", cnt, 0);
    tick(10);
    chk("cnt10", cnt, 10);
    sel = 3'd3; cat_n = 6'h37;
    tick(1);
    chk("flt_state", state, 2); chk("flt_pluto", pluto, 6'h08); chk("flt_cnt", cnt, 10);
    chk("flt_sdo", sdo, 1); chk("flt_step", step, 0);
    tick(3);
    chk("seq3_step", step, 3); chk("seq3_done", done, 0);
    tick(1);
    chk("done", done, 1); chk("done_state", state, 3); chk("done_step", step, 3); chk("done_active", active, 0);
    kbg_n = 1'b0;
    tick(1);
    kbg_n = 1'b1;
    chk("done_kill_ign", state, 3); chk("done_ek", ek, 0);
    clr = 1'b1; start = 1'b1;
    tick(1);
    clr = 1'b0; start = 1'b0;
    chk("clr_start", state, 0); chk("clr_pluto_kept", pluto, 6'h08); chk("clr_sdo", sdo, 0);
    // timeout with no fault
    cat_n = 6'h3F;
    pulse_start();
    tick(82);
    chk("cnt82", cnt, 82); chk("pre_to_state", state, 1);
    tick(1);
    chk("to_state", state, 4); chk("to_et", et, 1); chk("to_cnt", cnt, 82); chk("to_active", active, 0);
    pulse_start();
    chk("to_start_ign", state, 4);
    pulse_clr();
    chk("to_clr_state", state, 0); chk("to_clr_et", et, 1); chk("to_clr_cnt", cnt, 0);
    // kill during sequence step 1
    pulse_start();
    cat_n = 6'h37;
    tick(1);
    chk("k_seq", state, 2);
    tick(1);
    chk("k_step1", step, 1);
    kbg_n = 1'b0;
    tick(1);
    kbg_n = 1'b1;
    chk("kill_state", state, 5); chk("kill_ek", ek, 1); chk("kill_step", step, 1);
    tick(2);
    chk("kill_hold", state, 5); chk("kill_step_hold", step, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst2_state", state, 0); chk("rst2_pluto", pluto, 0); chk("rst2_et", et, 0); chk("rst2_ek", ek, 0);
    // out-of-range select, then fault coincident with terminal count
    sel = 3'd7; cat_n = 6'h00;
    pulse_start();
    tick(5);
    chk("oor_cnt", cnt, 5); chk("oor_state", state, 1); chk("oor_sdo", sdo, 0); chk("oor_pluto", pluto, 0);
    tick(77);
    chk("oor_cnt82", cnt, 82);
    sel = 3'd2;
    tick(1);
    chk("tie_state", state, 4); chk("tie_pluto", pluto, 0); chk("tie_et", et, 1); chk("tie_sdo", sdo, 1);
    // watch_en low holds, then kill beats fault
    pulse_clr();
    sel = 3'd7;
    pulse_start();
    watch_en = 1'b0;
    tick(3);
    chk("hold_cnt", cnt, 0); chk("hold_state", state, 1);
    sel = 3'd2; kbg_n = 1'b0; watch_en = 1'b1;
    tick(1);
    kbg_n = 1'b1;
    chk("kf_state", state, 5); chk("kf_pluto", pluto, 0); chk("kf_ek", ek, 1);
    // wide configuration
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    sel2 = 4'd11; cat2 = 12'hFFF;
    pulse_start();
    chk("w_arm", state2, 1);
    cat2 = 12'h7FF;
    tick(1);
    chk("w_flt_state", state2, 2); chk("w_pluto11", pluto2, 12'h800);
    tick(4);
    chk("w_done", done2, 1);
    pulse_start();
    chk("w_rearm", state2, 1); chk("w_rearm_cnt", cnt2, 0); chk("w_rearm_pluto", pluto2, 12'h800);
    sel2 = 4'd0; cat2 = 12'hFFE;
    tick(1);
    chk("w_pluto801", pluto2, 12'h801); chk("w_flt2_state", state2, 2);
    pulse_clr();
    cat2 = 12'hFFF;
    pulse_start();
    tick(600);
    chk("w_cnt600", cnt2, 600); chk("w_pre_to", state2, 1);
    tick(1);
    chk("w_to", state2, 4); chk("w_et", et2, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
